// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction RAM: packs little-endian bytes
// into words, writes them from word 0 and releases the core on a good checksum.
module imem_loader #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   input  logic                  load_req,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic [1:0]            err
);

   localparam int unsigned LEN_W = 16;
   localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
   localparam logic [1:0]  ERR_NONE = 2'b00;
   localparam logic [1:0]  ERR_LEN  = 2'b01;
   localparam logic [1:0]  ERR_CSUM = 2'b10;

   typedef enum logic [2:0] {
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t                r_state;
   logic [LEN_W-1:0]      r_len;
   logic [LEN_W-1:0]      r_widx;
   logic [1:0]            r_bidx;
   logic [7:0]            r_sum;
   logic [23:0]           r_asm;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic                  r_hold;
   logic                  r_done;
   logic [1:0]            r_err;

   state_t                w_state_nxt;
   logic [LEN_W-1:0]      w_len_nxt;
   logic [LEN_W-1:0]      w_len_full;
   logic [LEN_W-1:0]      w_widx_nxt;
   logic [1:0]            w_bidx_nxt;
   logic [7:0]            w_sum_nxt;
   logic [23:0]           w_asm_nxt;
   logic                  w_we_nxt;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic [31:0]           w_wdata_nxt;
   logic                  w_hold_nxt;
   logic                  w_done_nxt;
   logic [1:0]            w_err_nxt;
   logic                  w_ready_st;
   logic                  w_xfer;

   // in_ready is gated by rstn so it reads 0 during reset and 1 right after release
   assign in_ready   = rstn & w_ready_st;
   assign w_xfer     = in_valid & in_ready;
   assign w_len_full = {in_data, r_len[7:0]};

   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign cpu_hold   = r_hold;
   assign done       = r_done;
   assign err        = r_err;

   // State register and datapath registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_LEN0;
         r_len   <= '0;
         r_widx  <= '0;
         r_bidx  <= '0;
         r_sum   <= '0;
         r_asm   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_hold  <= 1'b1;
         r_done  <= 1'b0;
         r_err   <= ERR_NONE;
      end else begin
         r_state <= w_state_nxt;
         r_len   <= w_len_nxt;
         r_widx  <= w_widx_nxt;
         r_bidx  <= w_bidx_nxt;
         r_sum   <= w_sum_nxt;
         r_asm   <= w_asm_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_hold  <= w_hold_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Next-state and next-register logic
   always_comb begin
      w_state_nxt = r_state;
      w_len_nxt   = r_len;
      w_widx_nxt  = r_widx;
      w_bidx_nxt  = r_bidx;
      w_sum_nxt   = r_sum;
      w_asm_nxt   = r_asm;
      w_we_nxt    = 1'b0;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_hold_nxt  = r_hold;
      w_done_nxt  = r_done;
      w_err_nxt   = r_err;
      w_ready_st  = 1'b0;

      unique case (r_state)
         S_LEN0: begin
            w_ready_st = 1'b1;
            if (w_xfer) begin
               w_len_nxt   = {r_len[15:8], in_data};
               w_state_nxt = S_LEN1;
            end
         end
         S_LEN1: begin
            w_ready_st = 1'b1;
            if (w_xfer) begin
               w_len_nxt  = w_len_full;
               w_widx_nxt = '0;
               w_bidx_nxt = '0;
               w_sum_nxt  = '0;
               if (32'(w_len_full) > DEPTH) begin
                  w_state_nxt = S_ERR;
                  w_err_nxt   = ERR_LEN;
               end else if (w_len_full == '0) begin
                  w_state_nxt = S_CSUM;
               end else begin
                  w_state_nxt = S_DATA;
               end
            end
         end
         S_DATA: begin
            w_ready_st = 1'b1;
            if (w_xfer) begin
               w_sum_nxt  = r_sum + in_data;
               w_asm_nxt  = {in_data, r_asm[23:8]};
               w_bidx_nxt = r_bidx + 2'd1;
               // Fourth byte completes the word; the index wraps after a full-depth frame
               if (r_bidx == 2'd3) begin
                  w_we_nxt    = 1'b1;
                  w_addr_nxt  = r_widx[ADDR_WIDTH-1:0];
                  w_wdata_nxt = {in_data, r_asm};
                  w_widx_nxt  = r_widx + 16'd1;
                  if (r_widx == r_len - 16'd1) begin
                     w_state_nxt = S_CSUM;
                  end
               end
            end
         end
         S_CSUM: begin
            w_ready_st = 1'b1;
            if (w_xfer) begin
               if (in_data == r_sum) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
                  w_hold_nxt  = 1'b0;
               end else begin
                  w_state_nxt = S_ERR;
                  w_err_nxt   = ERR_CSUM;
               end
            end
         end
         S_DONE, S_ERR: begin
            if (load_req) begin
               w_state_nxt = S_LEN0;
               w_hold_nxt  = 1'b1;
               w_done_nxt  = 1'b0;
               w_err_nxt   = ERR_NONE;
            end
         end
         default: begin
            w_state_nxt = S_LEN0;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares every imem_we pulse.
module tb_imem_loader;

   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          load_req = 1'b0;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_hold;
   logic          done;
   logic [1:0]    err;

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .load_req   (load_req),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            failures = 0;
   int            n_wr = 0;
   logic [AW-1:0] q_addr[$];
   logic [31:0]   q_data[$];
   logic [AW-1:0] mon_ea;
   logic [31:0]   mon_ed;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_wr(input logic [AW-1:0] a, input logic [31:0] d);
      q_addr.push_back(a);
      q_data.push_back(d);
   endtask

   // Monitor: every write pulse must match the oldest expected write
   always @(negedge clk) begin
      if (rstn && imem_we) begin
         n_wr++;
         if (q_addr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", imem_addr, imem_wdata);
         end else begin
            mon_ea = q_addr.pop_front();
            mon_ed = q_data.pop_front();
            chk("wr_addr", 32'(imem_addr), 32'(mon_ea));
            chk("wr_data", imem_wdata, mon_ed);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      @(negedge clk);
      if (gaps) begin
         n = $urandom_range(0, 3);
         repeat (n) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!in_ready) begin
         failures++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 for byte 0x%0h", b);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic send_list(input logic [7:0] bl[$], input bit gaps);
      foreach (bl[i]) send_byte(bl[i], gaps);
   endtask

   task automatic pulse_load();
      @(negedge clk);
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
      @(negedge clk);
      chk("reload_hold", 32'(cpu_hold), 32'd1);
      chk("reload_ready", 32'(in_ready), 32'd1);
      chk("reload_done", 32'(done), 32'd0);
      chk("reload_err", 32'(err), 32'd0);
   endtask

   task automatic chk_status(input string tag, input logic d, input logic h, input logic [1:0] e);
      chk({tag, "_done"}, 32'(done), 32'(d));
      chk({tag, "_hold"}, 32'(cpu_hold), 32'(h));
      chk({tag, "_err"}, 32'(err), 32'(e));
      chk({tag, "_ready"}, 32'(in_ready), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  fr[$];
      logic [7:0]  b0, b1, b2, b3, sum;
      int          wr0;

      // Reset values while rstn is low
      #12;
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("rel_ready", 32'(in_ready), 32'd1);
      chk("rel_hold", 32'(cpu_hold), 32'd1);

      // Two-word frame, good checksum
      wr0 = n_wr;
      exp_wr(8'd0, 32'h0000_0013);
      exp_wr(8'd1, 32'h0010_0093);
      fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      send_list(fr, 1'b0);
      chk("two_hold_before_csum", 32'(cpu_hold), 32'd1);
      send_byte(8'hB6, 1'b0);
      @(negedge clk);
      chk_status("two_ok", 1'b1, 1'b0, 2'b00);
      chk("two_ok_nwr", 32'(n_wr - wr0), 32'd2);
      pulse_load();

      // Same frame, bad checksum
      wr0 = n_wr;
      exp_wr(8'd0, 32'h0000_0013);
      exp_wr(8'd1, 32'h0010_0093);
      send_list(fr, 1'b0);
      send_byte(8'h00, 1'b0);
      @(negedge clk);
      chk_status("bad_csum", 1'b0, 1'b1, 2'b10);
      chk("bad_csum_nwr", 32'(n_wr - wr0), 32'd2);
      pulse_load();

      // Length overflow: 0x0101 words with an 8-bit address
      wr0 = n_wr;
      fr = '{8'h01, 8'h01};
      send_list(fr, 1'b0);
      @(negedge clk);
      chk_status("ovf", 1'b0, 1'b1, 2'b01);
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      chk("ovf_nwr", 32'(n_wr - wr0), 32'd0);
      chk("ovf_err_held", 32'(err), 32'd1);
      pulse_load();

      // Empty frame, then a one-word frame after reload
      wr0 = n_wr;
      fr = '{8'h00, 8'h00, 8'h00};
      send_list(fr, 1'b0);
      @(negedge clk);
      chk_status("empty", 1'b1, 1'b0, 2'b00);
      chk("empty_nwr", 32'(n_wr - wr0), 32'd0);
      pulse_load();
      exp_wr(8'd0, 32'hDEAD_BEEF);
      fr = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
      send_list(fr, 1'b0);
      @(negedge clk);
      chk_status("one_word", 1'b1, 1'b0, 2'b00);
      pulse_load();

      // Mid-frame reset while a write pulse is on the bus
      fr = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_list(fr, 1'b0);
      chk("pre_rst_we", 32'(imem_we), 32'd1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_we", 32'(imem_we), 32'd0);
      chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
      chk("mid_rst_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_addr", 32'(imem_addr), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("mid_rel_ready", 32'(in_ready), 32'd1);
      chk("mid_rel_hold", 32'(cpu_hold), 32'd1);

      // Full-depth 256-word frame with random valid gaps
      wr0 = n_wr;
      sum = 8'h00;
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      for (int i = 0; i < 256; i++) begin
         b0 = 8'(i);
         b1 = ~8'(i);
         b2 = 8'(i) ^ 8'h3C;
         b3 = 8'hA5 + 8'(i * 3);
         exp_wr(8'(i), {b3, b2, b1, b0});
         sum = sum + b0 + b1 + b2 + b3;
         send_byte(b0, 1'b1);
         send_byte(b1, 1'b1);
         send_byte(b2, 1'b1);
         send_byte(b3, 1'b1);
      end
      chk("full_hold_before_csum", 32'(cpu_hold), 32'd1);
      send_byte(sum, 1'b1);
      @(negedge clk);
      chk_status("full", 1'b1, 1'b0, 2'b00);
      chk("full_nwr", 32'(n_wr - wr0), 32'd256);
      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(q_addr.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
